csh_fill_seq: RTL

//   Cache refill sequencer, directly upstream of the cache data slices.

---
 rtl/csh_fill_pkg.sv | 52 +++++
 rtl/csh_fill_seq_if.sv | 35 +++
 rtl/csh_fill_fifo.sv | 57 +++++
 rtl/csh_fill_seq.sv | 124 ++++++++++++
 4 files changed

// File: rtl/csh_fill_pkg.sv
// Shared types, constants and helper functions for the cache refill sequencer.
package csh_fill_pkg;

  localparam int unsigned WORDS_PER_BLK = 4;
  localparam int unsigned DATA_W        = 36;
  localparam int unsigned WD_W          = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              par;
    logic [WD_W-1:0]   wd;
  } fifo_ent_t;

  // Parity bit that makes the 36 data bits plus parity contain an odd number of ones.
  function automatic logic odd_par(input logic [DATA_W-1:0] d);
    return ~(^d);
  endfunction

  // First word at or after 'from' (wrapping mod 4) whose mask bit is set.
  function automatic logic [WD_W-1:0] next_wd(input logic [WD_W-1:0] from,
                                              input logic [WORDS_PER_BLK-1:0] mask);
    logic [WD_W-1:0] r;
    logic [WD_W-1:0] p;
    logic            found;
    r     = from;
    found = 1'b0;
    for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
      p = from + WD_W'(i);
      if (!found && mask[p]) begin
        r     = p;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [2:0] popcnt(input logic [WORDS_PER_BLK-1:0] mask);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
      c = c + 3'(mask[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/csh_fill_seq_if.sv
// Request, memory-return and cache-write signal bundle of the refill sequencer.
interface csh_fill_seq_if #(
  parameter int unsigned IDX_W = 7
);
  logic              fill_start_h;
  logic [1:0]        fill_wd_h;
  logic [3:0]        fill_mask_h;
  logic [IDX_W-1:0]  fill_idx_h;
  logic              mem_data_vld_h;
  logic [35:0]       mem_data_h;
  logic              mem_par_h;
  logic              mem_data_rdy_h;
  logic              csh_wr_ok_h;
  logic [35:0]       mem_to_cache_h;
  logic              csh_par_bit_in_h;
  logic [IDX_W+1:0]  cache_adr_h;
  logic              cache_wr_l;
  logic              fill_busy_h;
  logic              fill_done_h;
  logic              fill_err_h;

  modport slave (
    input  fill_start_h, fill_wd_h, fill_mask_h, fill_idx_h,
    input  mem_data_vld_h, mem_data_h, mem_par_h, csh_wr_ok_h,
    output mem_data_rdy_h, mem_to_cache_h, csh_par_bit_in_h, cache_adr_h,
    output cache_wr_l, fill_busy_h, fill_done_h, fill_err_h
  );

  modport master (
    output fill_start_h, fill_wd_h, fill_mask_h, fill_idx_h,
    output mem_data_vld_h, mem_data_h, mem_par_h, csh_wr_ok_h,
    input  mem_data_rdy_h, mem_to_cache_h, csh_par_bit_in_h, cache_adr_h,
    input  cache_wr_l, fill_busy_h, fill_done_h, fill_err_h
  );
endinterface

// File: rtl/csh_fill_fifo.sv
// Skid buffer between memory return and cache write; push is ignored when full.
module csh_fill_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 39
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign dout_o  = mem_q[rp_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (do_push) wp_d = ptr_inc(wp_q);
    if (do_pop)  rp_d = ptr_inc(rp_q);
    if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      if (do_push) mem_q[wp_q] <= din_i;
    end
  end
endmodule

// File: rtl/csh_fill_seq.sv
// Cache refill sequencer: buffers a 4-word memory block and writes it to the cache in wrap order.
// Optional feature: define CSH_FILL_PAR_GEN_EN to regenerate write parity from the data.
module csh_fill_seq
  import csh_fill_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IDX_W      = 7
) (
  input logic           clk,
  input logic           crobar,
  csh_fill_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       mask_q, mask_d;
  logic [1:0]       pos_q, pos_d;
  logic [2:0]       exp_q, exp_d;
  logic [2:0]       rcv_q, rcv_d;
  logic [2:0]       wr_q, wr_d;
  logic             err_q, err_d;

  logic             full, empty, rdy, push, pop, par_bad, par_wr;
  fifo_ent_t        push_ent, head;

  csh_fill_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(fifo_ent_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (crobar),
    .push_i  (push),
    .din_i   (push_ent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign par_bad = (bus.mem_par_h != odd_par(bus.mem_data_h));

`ifdef CSH_FILL_PAR_GEN_EN
  // Poison the regenerated parity on a failing word so the read path sees the error again.
  assign par_wr = par_bad ? ~odd_par(bus.mem_data_h) : odd_par(bus.mem_data_h);
`else
  assign par_wr = bus.mem_par_h;
`endif

  assign rdy           = (state_q == ST_FILL) && !full && (rcv_q < exp_q);
  assign push          = bus.mem_data_vld_h && rdy;
  assign pop           = (state_q == ST_FILL) && !empty && bus.csh_wr_ok_h;
  assign push_ent.data = bus.mem_data_h;
  assign push_ent.par  = par_wr;
  assign push_ent.wd   = pos_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    pos_d   = pos_q;
    exp_d   = exp_q;
    rcv_d   = rcv_q;
    wr_d    = wr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.fill_start_h) begin
          idx_d   = bus.fill_idx_h;
          mask_d  = bus.fill_mask_h;
          exp_d   = popcnt(bus.fill_mask_h);
          pos_d   = next_wd(bus.fill_wd_h, bus.fill_mask_h);
          rcv_d   = '0;
          wr_d    = '0;
          err_d   = 1'b0;
          state_d = (popcnt(bus.fill_mask_h) == '0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        if (push) begin
          rcv_d = rcv_q + 3'd1;
          pos_d = next_wd(pos_q + 2'd1, mask_q);
          if (par_bad) err_d = 1'b1;
        end
        if (pop) begin
          wr_d = wr_q + 3'd1;
          if ((wr_q + 3'd1) == exp_q) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge crobar) begin
    if (crobar) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      pos_q   <= '0;
      exp_q   <= '0;
      rcv_q   <= '0;
      wr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      pos_q   <= pos_d;
      exp_q   <= exp_d;
      rcv_q   <= rcv_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Write bus is held at zero outside write cycles.
  assign bus.mem_data_rdy_h   = rdy;
  assign bus.cache_wr_l       = ~pop;
  assign bus.mem_to_cache_h   = pop ? head.data : '0;
  assign bus.csh_par_bit_in_h = pop ? head.par : 1'b0;
  assign bus.cache_adr_h      = pop ? {idx_q, head.wd} : '0;
  assign bus.fill_busy_h      = (state_q != ST_IDLE);
  assign bus.fill_done_h      = (state_q == ST_DONE);
  assign bus.fill_err_h       = err_q;
endmodule
